ram_arbiter: RTL and testbench

Two-port arbiter sequencing all accesses to the shared 64-bit `ram` block. It accepts requests from the instruction-fetch port (read-only) and the load/store port (read/write), grants one at a time with round-robin fairness, and drives the RAM's `rw`/`addr`/`write` inputs for exactly one cycle per access. It returns the read data and the RAM `exception` flag to the granted requester. It sits between the core's fetch/LSU units and `ram`.

---
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between the fetch (read-only) and load/store ports for a
// single shared 64-bit RAM: one access per three cycles (grant, access, response).
module ram_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  input  logic [DATA_W-1:0] ram_read,
  input  logic              ram_exception,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_we_q, lat_we_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              lat_port_q, lat_port_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              pick_d;

  // State, latch, response and error-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_F;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      lat_port_q  <= PORT_F;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      lat_port_q  <= lat_port_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state, arbitration and grant decode.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    lat_port_d  = lat_port_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    f_gnt       = 1'b0;
    d_gnt       = 1'b0;
    // On a tie the port that was not granted last wins.
    pick_d      = d_req & (~f_req | (last_q == PORT_F));
    case (state_q)
      IDLE: begin
        if (rst_n && (f_req || d_req)) begin
          if (pick_d) begin
            d_gnt       = 1'b1;
            lat_addr_d  = d_addr;
            lat_we_d    = d_we;
            lat_wdata_d = d_wdata;
            lat_port_d  = PORT_D;
            last_d      = PORT_D;
          end else begin
            f_gnt       = 1'b1;
            lat_addr_d  = f_addr;
            lat_we_d    = 1'b0;
            lat_wdata_d = '0;
            lat_port_d  = PORT_F;
            last_d      = PORT_F;
          end
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        rdata_d = (lat_we_q || ram_exception) ? '0 : ram_read;
        err_d   = ram_exception;
        if (ram_exception && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM drive comes only from state and latches, never from requester inputs.
  assign ram_rw    = (state_q == ACCESS) & lat_we_q;
  assign ram_addr  = (state_q == ACCESS) ? lat_addr_q : '0;
  assign ram_write = (state_q == ACCESS) ? lat_wdata_q : '0;

  assign f_rvalid = (state_q == RESP) & (lat_port_q == PORT_F);
  assign d_rvalid = (state_q == RESP) & (lat_port_q == PORT_D);
  assign f_rdata  = f_rvalid ? rdata_q : '0;
  assign d_rdata  = d_rvalid ? rdata_q : '0;
  assign f_err    = f_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a 4 KiB behavioural RAM that
// faults on misaligned or out-of-range addresses.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] f_addr = 64'd0, d_addr = 64'd0, d_wdata = 64'd0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, ram_rw, ram_exception;
  logic [63:0] f_rdata, d_rdata, ram_addr, ram_write, ram_read;
  logic [7:0]  err_cnt;

  int n_chk = 0, n_fail = 0, cyc = 0;

  ram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_read(ram_read), .ram_exception(ram_exception), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) ^ 32'h5EED_0000, 32'(i * 7 + 3)};
  endfunction

  function automatic logic exc_f(input logic [63:0] a);
    return (a[2:0] != 3'd0) || (a >= 64'd4096);
  endfunction

  // Behavioural RAM (the real `ram` block's contract)
  logic [63:0] mem [512];
  bit          init_done = 1'b0;
  assign ram_exception = exc_f(ram_addr);
  assign ram_read      = (ram_addr < 64'd4096) ? mem[ram_addr[11:3]] : 64'd0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (ram_rw && !ram_exception) begin
      mem[ram_addr[11:3]] <= ram_write;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory of committed writes, plus arbitration rules
  logic [63:0] sh [int];
  function automatic logic [63:0] sh_rd(input int i);
    return sh.exists(i) ? sh[i] : init_word(i);
  endfunction

  typedef struct {
    logic        port;
    logic [63:0] rdata;
    logic        err;
    int          due;
  } resp_t;
  resp_t q[$];

  int          busy = 0;
  logic        m_last = 1'b0;
  logic        pend = 1'b0, p_we = 1'b0;
  logic [63:0] p_addr = 64'd0, p_wdata = 64'd0;
  int          exp_cnt = 0;

  // Grant/access model: predicts grants and RAM drive, pushes expected responses
  always @(negedge clk) begin : model
    logic        exp_d, exp_f, we, e;
    logic [63:0] a, wd;
    if (!rst_n) begin
      busy = 0; m_last = 1'b0; pend = 1'b0;
      chk("gnt_in_reset", {f_gnt, d_gnt}, 64'd0);
      chk("ram_rw_in_reset", ram_rw, 64'd0);
    end else begin
      if (pend) begin
        chk("ram_rw", ram_rw, p_we);
        chk("ram_addr", ram_addr, p_addr);
        chk("ram_write", ram_write, p_wdata);
        if (p_we && !exc_f(p_addr)) sh[int'(p_addr[11:3])] = p_wdata;
        pend = 1'b0;
      end else begin
        chk("ram_idle", {63'd0, ram_rw} | ram_addr | ram_write, 64'd0);
      end
      exp_d = (busy == 0) && d_req && (!f_req || m_last == 1'b0);
      exp_f = (busy == 0) && f_req && !exp_d;
      chk("gnt", {f_gnt, d_gnt}, {exp_f, exp_d});
      if (exp_d || exp_f) begin
        a  = exp_d ? d_addr : f_addr;
        we = exp_d & d_we;
        wd = exp_d ? d_wdata : 64'd0;
        e  = exc_f(a);
        q.push_back('{exp_d, (we || e) ? 64'd0 : sh_rd(int'(a[11:3])), e, cyc + 2});
        pend = 1'b1; p_addr = a; p_we = we; p_wdata = wd;
        m_last = exp_d;
        busy = 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents rvalid
  always @(negedge clk) begin : monitor
    resp_t r;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      chk("rvalid_in_reset", {f_rvalid, d_rvalid}, 64'd0);
      chk("err_cnt_in_reset", err_cnt, 64'd0);
    end else begin
      if (!f_rvalid) chk("f_idle_out", {f_rdata[62:0], f_err}, 64'd0);
      if (!d_rvalid) chk("d_idle_out", {d_rdata[62:0], d_err}, 64'd0);
      if (f_rvalid || d_rvalid) begin
        chk("one_rvalid", f_rvalid & d_rvalid, 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_rvalid", {f_rvalid, d_rvalid}, 64'd0);
        end else begin
          r = q.pop_front();
          chk("rvalid_port", d_rvalid, r.port);
          chk("rvalid_cycle", 64'(cyc), 64'(r.due));
          chk("rdata", d_rvalid ? d_rdata : f_rdata, r.rdata);
          chk("err", d_rvalid ? d_err : f_err, r.err);
          if (r.err && exp_cnt < 255) exp_cnt++;
          chk("err_cnt", err_cnt, 64'(exp_cnt));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_rvalid", 64'd0, 64'd1);
        void'(q.pop_front());
      end
    end
  end

  // Request drivers: called at posedge+1, return at posedge+1 after the grant
  task automatic f_acc(input logic [63:0] a);
    int n = 0;
    f_req = 1'b1; f_addr = a;
    @(negedge clk);
    while (!f_gnt && n < 60) begin @(negedge clk); n++; end
    chk("f_gnt_wait", f_gnt, 64'd1);
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic d_acc(input logic we, input logic [63:0] a, input logic [63:0] wd);
    int n = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    @(negedge clk);
    while (!d_gnt && n < 60) begin @(negedge clk); n++; end
    chk("d_gnt_wait", d_gnt, 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports requesting from reset: d, f, d, f; data port writes then reads 0x40
    fork
      begin
        d_acc(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
        d_acc(1'b0, 64'h40, 64'd0);
      end
      begin
        f_acc(64'h800);
        f_acc(64'h808);
      end
    join
    repeat (4) @(posedge clk); #1;

    // Misaligned fetch, faulted store at 2^63, then read of 0x0
    f_acc(64'h42);
    d_acc(1'b1, 64'h8000_0000_0000_0000, 64'h1234);
    d_acc(1'b0, 64'h0, 64'd0);
    repeat (4) @(posedge clk); #1;

    // Reset in the middle of the ACCESS cycle of a write to 0x80
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("rst_test_gnt", d_gnt, 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ram_rw_drop", ram_rw, 64'd0);
    chk("rst_gnt_forced", d_gnt, 64'd0);
    chk("rst_err_cnt", err_cnt, 64'd0);
    repeat (2) @(posedge clk);
    #3 d_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ram_0x80_kept", mem[16], init_word(16));
    d_acc(1'b0, 64'h80, 64'd0);

    // Random traffic: fetch reads upper half, data writes lower half
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          logic [63:0] a;
          a = 64'h800 + 64'($urandom_range(0, 255)) * 64'd8;
          if ($urandom_range(0, 5) == 0) a = a + 64'($urandom_range(1, 7));
          f_acc(a);
          gap();
        end
      end
      begin
        for (int j = 0; j < 120; j++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 4)
            d_acc(1'b1, 64'($urandom_range(0, 255)) * 64'd8, {$urandom(), $urandom()});
          else if (r < 8)
            d_acc(1'b0, 64'($urandom_range(0, 511)) * 64'd8, 64'd0);
          else
            d_acc(1'($urandom_range(0, 1)), 64'h1000 + 64'($urandom_range(0, 4095)), 64'hBAD);
          gap();
        end
      end
    join

    // Saturation of the error counter
    for (int k = 0; k < 300; k++) f_acc(64'h800 + 64'(k % 7) + 64'd1);
    repeat (6) @(negedge clk);
    chk("err_cnt_saturated", err_cnt, 64'd255);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
